// File: rtl/ram_fifo_ctrl.sv
// FIFO sequencer wrapping a single-port async RAM: valid/ready push/pop handshakes,
// one RAM access in flight, occupancy/error tracking and read/write arbitration.
module ram_fifo_ctrl #(
  parameter int DW    = 8,
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          out_req,
  output logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ovf,
  output logic          udf,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data_in,
  output logic          ram_rd,
  output logic          ram_wr,
  output logic          ram_cs,
  input  logic [DW-1:0] ram_d_out
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WR     = 2'd1;
  localparam logic [1:0] RD     = 2'd2;
  localparam logic [1:0] RD_CAP = 2'd3;

  localparam logic PRIO_W = 1'b0;
  localparam logic PRIO_R = 1'b1;

  logic [1:0]    state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          prio;
  logic          idle;
  logic          cand_w;
  logic          cand_r;
  logic          grant_w;
  logic          grant_r;

  assign idle  = (state == IDLE);
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  always_comb begin
    cand_w    = idle & in_valid & ~full;
    cand_r    = idle & out_req & ~empty;
    grant_w   = cand_w & (~cand_r | (prio == PRIO_W));
    grant_r   = cand_r & (~cand_w | (prio == PRIO_R));
    in_ready  = idle & ~full & ~(cand_r & (prio == PRIO_R));
    out_ready = idle & ~empty & ~(cand_w & (prio == PRIO_W));
  end

  // Strobes decode straight from state so an async reset drops them immediately.
  always_comb begin
    ram_cs   = (state != IDLE);
    ram_wr   = (state == WR);
    ram_rd   = (state == RD) | (state == RD_CAP);
    ram_addr = '0;
    if (state == WR) ram_addr = wr_ptr;
    else if (ram_rd) ram_addr = rd_ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      prio        <= PRIO_W;
      ovf         <= 1'b0;
      udf         <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      ram_data_in <= '0;
    end else if (flush) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      prio      <= PRIO_W;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (idle && in_valid && full) ovf <= 1'b1;
      if (idle && out_req && empty) udf <= 1'b1;
      case (state)
        IDLE: begin
          if (cand_w && cand_r) prio <= ~prio;
          if (grant_w) begin
            ram_data_in <= in_data;
            state       <= WR;
          end else if (grant_r) begin
            state <= RD;
          end
        end
        WR: begin
          wr_ptr <= wr_ptr + 1'b1;
          count  <= count + 1'b1;
          state  <= IDLE;
        end
        RD: state <= RD_CAP;
        RD_CAP: begin
          out_data  <= ram_d_out;
          out_valid <= 1'b1;
          rd_ptr    <= rd_ptr + 1'b1;
          count     <= count - 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl: queue-based FIFO reference model, async RAM model,
// directed scenarios followed by randomized push/pop/flush traffic.
module tb_ram_fifo_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_req;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          ovf;
  logic          udf;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic          ram_rd;
  logic          ram_wr;
  logic          ram_cs;
  logic [DW-1:0] ram_d_out;

  logic [DW-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_req(out_req), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .full(full), .empty(empty), .count(count), .ovf(ovf), .udf(udf),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_cs(ram_cs), .ram_d_out(ram_d_out)
  );

  // Async RAM: combinational read, write committed while wr is held.
  always @(posedge clk) if (ram_cs && ram_wr) mem[ram_addr] <= ram_data_in;
  assign ram_d_out = (ram_cs && ram_rd) ? mem[ram_addr] : '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: contents as a queue, one pending op with its completion edge.
  logic [DW-1:0] q[$];
  int            pend_kind = 0;  // 0 none, 1 write, 2 read
  int            done_at = 0;
  logic [DW-1:0] pend_data;
  logic          m_prio = 1'b0;  // 0 = write wins next contest
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;
  int            wr_total = 0;

  typedef struct packed { logic [DW-1:0] data; int at; } rd_exp_t;
  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_exp_t;
  rd_exp_t rd_sb[$];
  wr_exp_t wr_sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    pend_kind = 0;
    m_prio    = 1'b0;
    m_ovf     = 1'b0;
    m_udf     = 1'b0;
    wr_total  = 0;
  endtask

  // One clock cycle: drive, check visible state against the model, advance the model.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic orq, input logic fl);
    logic idle, fm, em, cw, cr, gw, gr;
    @(negedge clk);
    in_valid = iv;
    in_data  = d;
    out_req  = orq;
    flush    = fl;
    #1;
    idle = (pend_kind == 0);
    fm   = (q.size() == DEPTH);
    em   = (q.size() == 0);
    cw   = idle && iv && !fm;
    cr   = idle && orq && !em;
    gw   = cw && (!cr || !m_prio);
    gr   = cr && (!cw || m_prio);
    chk("in_ready", in_ready, idle && !fm && !(cr && m_prio));
    chk("out_ready", out_ready, idle && !em && !(cw && !m_prio));
    chk("count", count, q.size());
    chk("full", full, fm);
    chk("empty", empty, em);
    chk("ovf", ovf, m_ovf);
    chk("udf", udf, m_udf);
    chk("ram_wr", ram_wr, pend_kind == 1);
    chk("ram_rd", ram_rd, pend_kind == 2);
    chk("ram_cs", ram_cs, pend_kind != 0);
    @(posedge clk);
    cyc++;
    if (fl) begin
      model_clear();
    end else begin
      if (idle && iv && fm) m_ovf = 1'b1;
      if (idle && orq && em) m_udf = 1'b1;
      if (pend_kind == 1 && cyc == done_at) begin
        q.push_back(pend_data);
        pend_kind = 0;
      end else if (pend_kind == 2 && cyc == done_at) begin
        rd_sb.push_back('{data: q.pop_front(), at: cyc});
        pend_kind = 0;
      end
      if (cw && cr) m_prio = !m_prio;
      if (gw) begin
        pend_kind = 1;
        done_at   = cyc + 1;
        pend_data = d;
        wr_sb.push_back('{addr: AW'(wr_total % DEPTH), data: d});
        wr_total++;
      end
      if (gr) begin
        pend_kind = 2;
        done_at   = cyc + 2;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_cs", ram_cs, 0);
    chk("rst_rd", ram_rd, 0);
    chk("rst_wr", ram_wr, 0);
    chk("rst_out_valid", out_valid, 0);
    model_clear();
    wr_sb.delete();
    rd_sb.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_data_in", ram_data_in, 0);
    rst_n = 1'b1;
  endtask

  // Monitor: pops expected RAM writes and read results as the DUT presents them.
  initial begin
    wr_exp_t we;
    rd_exp_t re;
    forever begin
      @(negedge clk);
      chk("rd_wr_exclusive", ram_rd & ram_wr, 0);
      if (ram_wr) begin
        chk("write_expected", wr_sb.size() > 0, 1);
        if (wr_sb.size() > 0) begin
          we = wr_sb.pop_front();
          chk("wr_addr", ram_addr, we.addr);
          chk("wr_data", ram_data_in, we.data);
        end
      end
      if (out_valid) begin
        chk("pop_expected", rd_sb.size() > 0, 1);
        if (rd_sb.size() > 0) begin
          re = rd_sb.pop_front();
          chk("out_data", out_data, re.data);
          chk("out_latency_cycle", cyc, re.at);
        end
      end
    end
  end

  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    out_req  = 1'b0;
    flush    = 1'b0;
    rst_n    = 1'b1;
    #2;
    do_reset();

    // Ordering
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill to full, overflow, then wrap the write pointer
    step(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (2 * DEPTH) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);

    // Contention from count=5
    step(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (5) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
    end
    repeat (12) step(1'b1, 8'($urandom), 1'b1, 1'b0);
    repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0);

    // Underflow, cleared by flush
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Abort during RD_CAP: async reset, then flush
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rdcap_rd_active", ram_rd, 1);
    #2;
    do_reset();
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);

    // Randomized traffic with shifting push/pop bias
    for (int seg = 0; seg < 6; seg++) begin
      int unsigned pw, pr;
      pw = $urandom_range(10, 90);
      pr = $urandom_range(10, 90);
      repeat (500) begin
        step($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
             $urandom_range(0, 199) == 0);
      end
    end

    repeat (5) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rd_sb_drained", rd_sb.size(), 0);
    chk("wr_sb_drained", wr_sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
